// File: rtl/sha256_pkg.sv
// Shared types and sigma helpers for the streaming SHA-256 schedule.
package sha256_pkg;

    localparam int BLOCK_W   = 512;
    localparam int WORD_W    = 32;
    localparam int WIN_DEPTH = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t shr(input word_t x, input int unsigned n);
        return x >> n;
    endfunction

    function automatic word_t s0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
    endfunction

    function automatic word_t s1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
    endfunction

endpackage

// File: rtl/sha256_sched_lane.sv
// One channel: rolling 16-word schedule window with the recurrence adder.
module sha256_sched_lane
    import sha256_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [BLOCK_W-1:0] blk,
    output word_t              w
);

    word_t win_q [WIN_DEPTH];
    word_t win_d [WIN_DEPTH];

    always_comb begin
        win_d = win_q;
        if (load) begin
            // word 0 sits in the block's MSBs
            for (int k = 0; k < WIN_DEPTH; k++) begin
                win_d[k] = blk[BLOCK_W-1-WORD_W*k -: WORD_W];
            end
        end else if (shift) begin
            for (int k = 0; k < WIN_DEPTH-1; k++) begin
                win_d[k] = win_q[k+1];
            end
            win_d[WIN_DEPTH-1] = s1(win_q[14]) + win_q[9]
                               + s0(win_q[1]) + win_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < WIN_DEPTH; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            win_q <= win_d;
        end
    end

    assign w = win_q[0];

endmodule

// File: rtl/sha256_sched_stream.sv
// Streaming SHA-256 message schedule for NUM_CH blocks in lockstep.
module sha256_sched_stream
    import sha256_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ROUNDS = 64,
    parameter int T_W    = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_CH*BLOCK_W-1:0] in_block,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CH*WORD_W-1:0]  out_w,
    output logic [T_W-1:0]            out_t,
    output logic                      out_last,
    output logic                      busy
);

    state_e         state_q;
    state_e         state_d;
    logic [T_W-1:0] t_q;
    logic [T_W-1:0] t_d;
    logic           load;
    logic           shift;
    logic           last_t;

    assign last_t = (t_q == T_W'(ROUNDS-1));

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        load      = 1'b0;
        shift     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    t_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    shift = 1'b1;
                    t_d   = t_q + T_W'(1);
                    if (last_t) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    assign out_t    = t_q;
    assign out_last = out_valid && last_t;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        sha256_sched_lane u_lane (
            .clk   (clk),
            .rst   (rst),
            .load  (load),
            .shift (shift),
            .blk   (in_block[c*BLOCK_W +: BLOCK_W]),
            .w     (out_w[c*WORD_W +: WORD_W])
        );
    end

endmodule

// File: tb/tb_sha256_sched_stream.sv
// Bench for sha256_sched_stream: textbook schedule model plus directed vectors.
module tb_sha256_sched_stream;

    localparam int NCH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [NCH*512-1:0] in_block = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [NCH*32-1:0]  out_w;
    logic [5:0]         out_t;
    logic               out_last;
    logic               busy;

    logic         in_valid_b = 1'b0;
    logic         in_ready_b;
    logic [511:0] in_block_b = '0;
    logic         out_valid_b;
    logic         out_ready_b = 1'b0;
    logic [31:0]  out_w_b;
    logic [3:0]   out_t_b;
    logic         out_last_b;
    logic         busy_b;

    sha256_sched_stream #(.NUM_CH(NCH), .ROUNDS(64), .T_W(6)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_w(out_w), .out_t(out_t), .out_last(out_last), .busy(busy)
    );

    sha256_sched_stream #(.NUM_CH(1), .ROUNDS(16), .T_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_block(in_block_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_w(out_w_b), .out_t(out_t_b), .out_last(out_last_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int cyc = 0;
    int last_cyc = 0;
    int last_cnt = 0;
    int last_at = -1;

    logic [NCH*32-1:0] cap  [64];
    logic [NCH*32-1:0] cap1 [64];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
    endfunction

    // Reference: full 64-word schedule per block, textbook indexing
    bit          m_run = 0;
    int          m_t = 0;
    logic [31:0] msched [NCH][64];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", out_valid, m_run);
            chk("in_ready", in_ready, !m_run);
            chk("busy", busy, m_run);
            chk("out_last", out_last, m_run && m_t == 63);
            if (m_run) begin
                chk("out_t", out_t, m_t);
                for (int c = 0; c < NCH; c++) begin
                    chk($sformatf("w ch%0d t%0d", c, m_t),
                        out_w[c*32 +: 32], msched[c][m_t]);
                end
            end
        end
        if (!rst) begin
            m_run = 0;
            m_t   = 0;
        end else if (!m_run) begin
            if (in_valid) begin
                for (int c = 0; c < NCH; c++) begin
                    for (int i = 0; i < 16; i++)
                        msched[c][i] = in_block[c*512 + 511 - 32*i -: 32];
                    for (int i = 16; i < 64; i++)
                        msched[c][i] = ss1(msched[c][i-2]) + msched[c][i-7]
                                     + ss0(msched[c][i-15]) + msched[c][i-16];
                end
                m_run = 1;
                m_t   = 0;
            end
        end else if (out_ready) begin
            if (m_t == 63) m_run = 0;
            else m_t++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_block(input logic [NCH*512-1:0] blk);
        in_block = blk;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL accept timeout: in_ready never seen");
    endtask

    task automatic run_stream(input int stall_at, input int stall_len,
                              input bit rnd, input int abort_at);
        int                stall_left = 0;
        bit                stalled = 0;
        logic [NCH*32-1:0] held = '0;
        last_cnt = 0;
        last_at  = -1;
        for (int i = 0; i < 64; i++) cap[i] = '0;
        for (int n = 0; n < 2000; n++) begin
            if (!out_valid) return;
            if (int'(out_t) == abort_at) return;
            if (!stalled && int'(out_t) == stall_at) begin
                stall_left = stall_len;
                stalled    = 1;
                held       = out_w;
            end
            if (stall_left > 0) begin
                chk("stall t", out_t, stall_at);
                chk("stall w", out_w, held);
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            end
            if (out_ready) begin
                cap[out_t] = out_w;
                if (out_last) begin
                    last_cnt++;
                    last_at  = int'(out_t);
                    last_cyc = cyc;
                end
            end
            tick();
        end
        checks++;
        errors++;
        $display("FAIL stream timeout: out_valid stuck high");
    endtask

    function automatic logic [NCH*512-1:0] rand_block();
        logic [NCH*512-1:0] b;
        for (int i = 0; i < NCH*16; i++) b[i*32 +: 32] = $urandom();
        return b;
    endfunction

    initial begin
        logic [NCH*512-1:0] abc;
        logic [NCH*512-1:0] b1;
        logic [NCH*512-1:0] b2;
        logic [31:0]        acc;
        int                 diffs;

        tick();
        tick();
        rst    = 1'b1;
        chk_en = 1;
        chk("rst out_valid", out_valid, 0);
        chk("rst out_last", out_last, 0);
        chk("rst busy", busy, 0);
        chk("rst out_w", out_w, 0);
        chk("rst out_t", out_t, 0);
        chk("rst in_ready", in_ready, 1);

        // "abc" padded block on ch0, other channels zero
        abc = '0;
        abc[511:480] = 32'h61626380;
        abc[31:0]    = 32'h00000018;
        send_block(abc);
        run_stream(-1, 0, 0, -1);
        for (int i = 0; i < 64; i++) cap1[i] = cap[i];
        chk("abc W0", cap[0][31:0], 32'h61626380);
        chk("abc W15", cap[15][31:0], 32'h00000018);
        chk("abc W16", cap[16][31:0], 32'h61626380);
        chk("abc W17", cap[17][31:0], 32'h000F0000);
        chk("model W16", msched[0][16], 32'h61626380);
        chk("model W17", msched[0][17], 32'h000F0000);
        acc = '0;
        for (int i = 0; i < 64; i++) acc |= cap[i][63:32];
        chk("ch1 all zero", acc, 0);
        chk("last count", last_cnt, 1);
        chk("last at 63", last_at, 63);

        // stall at t=20 for 5 cycles
        send_block(abc);
        run_stream(20, 5, 0, -1);
        diffs = 0;
        for (int i = 0; i < 64; i++) if (cap[i] !== cap1[i]) diffs++;
        chk("stall seq diffs", diffs, 0);

        // back-to-back with in_valid held high
        b1 = rand_block();
        b2 = rand_block();
        in_block = b1;
        in_valid = 1'b1;
        tick();
        in_block = b2;
        run_stream(-1, 0, 0, -1);
        chk("gap in_ready", in_ready, 1);
        tick();
        chk("restart valid", out_valid, 1);
        chk("restart t", out_t, 0);
        chk("accept gap", cyc - last_cyc, 2);
        in_valid = 1'b0;
        run_stream(-1, 0, 0, -1);

        // reset mid-stream at t=30
        send_block(rand_block());
        run_stream(-1, 0, 0, 30);
        chk("abort at t30", out_t, 30);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst busy", busy, 0);
        chk("mid rst in_ready", in_ready, 1);
        chk("mid rst out_t", out_t, 0);
        chk("mid rst out_w", out_w, 0);
        send_block(abc);
        run_stream(-1, 0, 0, -1);
        diffs = 0;
        for (int i = 0; i < 64; i++) if (cap[i] !== cap1[i]) diffs++;
        chk("post rst seq diffs", diffs, 0);

        // random blocks with random out_ready
        for (int b = 0; b < 5; b++) begin
            send_block(rand_block());
            run_stream(-1, 0, 1, -1);
            chk("rand last count", last_cnt, 1);
        end

        // ROUNDS=16, NUM_CH=1 instance
        for (int i = 0; i < 16; i++)
            in_block_b[511-32*i -: 32] = 32'hC0DE0000 + i;
        chk("b idle ready", in_ready_b, 1);
        in_valid_b = 1'b1;
        tick();
        in_valid_b  = 1'b0;
        out_ready_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("b valid", out_valid_b, 1);
            chk("b t", out_t_b, i);
            chk("b w", out_w_b, 32'hC0DE0000 + i);
            chk("b last", out_last_b, i == 15);
            tick();
        end
        chk("b end valid", out_valid_b, 0);
        chk("b end busy", busy_b, 0);
        chk("b end ready", in_ready_b, 1);
        tick();
        chk("b stays idle", out_valid_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
